// File: rtl/program_loader.sv
// Byte-stream program loader: receives a word count and little-endian words, writes them into
// instruction memory and releases the core from reset. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        imem_write_enable_o,
  output logic [31:0] imem_address_o,
  output logic [31:0] imem_data_o,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic        len_taken_q, len_taken_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, core_reset_q, done_q, error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic ready_state;
  logic accept;

  // LEN_HI drops ready for one cycle after the high byte so the count check sees a settled register.
  always_comb begin
    ready_state = 1'b0;
    unique case (state_q)
      StLenLo: ready_state = 1'b1;
      StLenHi: ready_state = ~len_taken_q;
      StData:  ready_state = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StCheck: ready_state = 1'b1;
`endif
      default: ready_state = 1'b0;
    endcase
  end

  assign byte_ready_o = ready_state & ~reset_i;
  assign accept       = byte_valid_i & byte_ready_o;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    len_taken_d = len_taken_q;
    lane_d      = lane_q;
    word_d      = word_q;
    addr_d      = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      StLenLo: begin
        if (accept) begin
          count_d[7:0] = byte_i;
          state_d      = StLenHi;
        end
      end
      StLenHi: begin
        if (len_taken_q) begin
          len_taken_d = 1'b0;
          if (count_q == 16'd0) begin
            state_d = StDone;
          end else if ({16'd0, count_q} > MAX_WORDS) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end else if (accept) begin
          count_d[15:8] = byte_i;
          len_taken_d   = 1'b1;
        end
      end
      StData: begin
        if (accept) begin
          word_d[{lane_q, 3'b000} +: 8] = byte_i;
          lane_d = lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_i;
`endif
          if (lane_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        index_d = index_q + 16'd1;
        addr_d  = addr_q + 32'd4;
        if (index_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          state_d = (byte_i == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Outputs are flopped from the next state so they line up exactly with the state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StLenLo;
      count_q      <= 16'd0;
      index_q      <= 16'd0;
      len_taken_q  <= 1'b0;
      lane_q       <= 2'd0;
      word_q       <= 32'd0;
      addr_q       <= BASE_ADDR;
      write_q      <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      index_q      <= index_d;
      len_taken_q  <= len_taken_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      write_q      <= (state_d == StWrite);
      core_reset_q <= (state_d != StDone);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StError);
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign imem_write_enable_o = write_q;
  assign imem_address_o      = addr_q;
  assign imem_data_o         = word_q;
  assign core_reset_o        = core_reset_q;
  assign done_o              = done_q;
  assign error_o             = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as words are sent and
// matched against write strobes sampled on the falling edge.
module tb_program_loader;

  localparam logic [31:0] Base     = 32'h0000_0000;
  localparam int unsigned MaxWords = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit WithCheck = 1'b1;
`else
  localparam bit WithCheck = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        imem_write_enable_o;
  logic [31:0] imem_address_o;
  logic [31:0] imem_data_o;
  logic        core_reset_o;
  logic        done_o;
  logic        error_o;

  program_loader #(
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxWords)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .byte_i             (byte_i),
    .byte_valid_i       (byte_valid_i),
    .byte_ready_o       (byte_ready_o),
    .imem_write_enable_o(imem_write_enable_o),
    .imem_address_o     (imem_address_o),
    .imem_data_o        (imem_data_o),
    .core_reset_o       (core_reset_o),
    .done_o             (done_o),
    .error_o            (error_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must be one cycle wide and match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_write_enable_o) begin
      check_eq("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        check_eq("write_addr_data", {imem_address_o, imem_data_o}, exp_q.pop_front());
      end
    end
    prev_we <= imem_write_enable_o;
  end

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(byte_ready_o), 64'd0);
    check_eq("rst_we", 64'(imem_write_enable_o), 64'd0);
    check_eq("rst_addr", 64'(imem_address_o), 64'(Base));
    check_eq("rst_data", 64'(imem_data_o), 64'd0);
    check_eq("rst_flags", {61'd0, core_reset_o, done_o, error_o}, 64'b100);
    reset_i = 1'b0;
    #1;
    check_eq("ready_after_rst", 64'(byte_ready_o), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (byte_ready_o) break;
      n++;
      if (n >= 40) begin
        check_eq("ready_timeout", 64'd0, 64'd1);
        byte_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic load(input logic [7:0] s[$], input int gap, input bit add_csum);
    int          cnt;
    logic [31:0] w;
    logic [7:0]  x;
    cnt = (s.size() >= 2) ? int'({s[1], s[0]}) : 0;
    w = 32'd0;
    x = 8'd0;
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], gap);
      if (i >= 2 && i < 2 + 4 * cnt) begin
        w[8 * ((i - 2) % 4) +: 8] = s[i];
        x = x ^ s[i];
        if ((i - 2) % 4 == 3 && cnt <= int'(MaxWords)) begin
          exp_q.push_back({Base + 32'(4 * ((i - 2) / 4)), w});
        end
      end
    end
    if (WithCheck && add_csum && cnt > 0) send_byte(x, gap);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done_o || error_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("end_reached", 64'(done_o | error_o), 64'd1);
  endtask

  task automatic expect_done();
    wait_end();
    check_eq("done_flags", {61'd0, core_reset_o, done_o, error_o}, 64'b010);
    check_eq("done_ready", 64'(byte_ready_o), 64'd0);
    check_eq("done_we", 64'(imem_write_enable_o), 64'd0);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_error();
    wait_end();
    check_eq("err_flags", {61'd0, core_reset_o, done_o, error_o}, 64'b101);
    check_eq("err_ready", 64'(byte_ready_o), 64'd0);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] big[$];

    do_reset();

    // Two-word program, back-to-back bytes.
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    load(s, 0, 1'b1);
    expect_done();

    // Same program with 5 idle cycles before every byte.
    do_reset();
    load(s, 5, 1'b1);
    expect_done();

    // Zero count: DONE appears two cycles after the second byte, with no write.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check_eq("zero_cnt_done_early", 64'(done_o), 64'd0);
    @(negedge clk);
    check_eq("zero_cnt_done", 64'(done_o), 64'd1);
    check_eq("zero_cnt_core_rst", 64'(core_reset_o), 64'd0);
    check_eq("zero_cnt_sb", 64'(exp_q.size()), 64'd0);

    // Count 257 exceeds MAX_WORDS.
    do_reset();
    s = '{8'h01, 8'h01};
    load(s, 0, 1'b0);
    expect_error();

    // Count exactly MAX_WORDS is accepted.
    do_reset();
    big = '{8'h00, 8'h01};
    for (int i = 0; i < 4 * 256; i++) big.push_back(8'($urandom_range(0, 255)));
    load(big, 0, 1'b1);
    expect_done();

    // Reset mid-word aborts; the next load starts again at BASE_ADDR.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 1);
    do_reset();
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(s, 0, 1'b1);
    expect_done();

    if (WithCheck) begin
      do_reset();
      s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      load(s, 0, 1'b0);
      expect_done();
      do_reset();
      s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      load(s, 0, 1'b0);
      expect_error();
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, 32'h00000000, byte address of the first instruction-memory word written.
REQ-002 Parameter MAX_WORDS, 256, largest accepted word count; range 1..65535.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 byte_i  input  8  incoming load-stream byte.
REQ-006 byte_valid_i  input  1  byte_i holds a valid byte.
REQ-007 byte_ready_o  output  1  loader accepts byte_i this cycle.
REQ-008 imem_write_enable_o  output  1  one-cycle instruction-memory write strobe.
REQ-009 imem_address_o  output  32  word-aligned instruction-memory byte address.
REQ-010 imem_data_o  output  32  instruction word to write.
REQ-011 core_reset_o  output  1  holds the softcore in reset while high.
REQ-012 done_o  output  1  load completed successfully.
REQ-013 error_o  output  1  load aborted; the core stays in reset.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where byte_valid_i and byte_ready_o are both high.
REQ-015 Stream format SHALL be: count low byte, count high byte, then count words of 4 bytes each, least-significant byte first.
REQ-016 States SHALL be LEN_LO, LEN_HI, DATA, WRITE, (CHECK), DONE, ERROR.
REQ-017 byte_ready_o SHALL be high only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-018 The cycle after LEN_HI accepts a byte, the loader SHALL go to DONE if the count is 0, to ERROR if the count exceeds MAX_WORDS, and to DATA otherwise.
REQ-019 DATA SHALL shift bytes into a 32-bit assembly register, byte k into bits [8k+7:8k]. After the 4th byte it SHALL go to WRITE on the next edge.
REQ-020 WRITE SHALL last exactly one cycle, with imem_write_enable_o=1, imem_address_o=BASE_ADDR+4*index and imem_data_o=the assembled word.
REQ-021 Leaving WRITE SHALL increment the index. When index equals count, the loader SHALL go to CHECK (if compiled in) or DONE; otherwise it SHALL return to DATA.
REQ-022 imem_write_enable_o SHALL be 0 in every state except WRITE.
REQ-023 Address arithmetic SHALL be 32-bit modulo 2^32. The index counter SHALL be 16 bits wide.
REQ-024 Gaps of any length in byte_valid_i SHALL stall the loader without losing state.
REQ-025 DONE SHALL drive core_reset_o=0, done_o=1, byte_ready_o=0 and hold until reset_i.
REQ-026 ERROR SHALL drive error_o=1, core_reset_o=1, byte_ready_o=0 and hold until reset_i.
REQ-027 core_reset_o SHALL be 1 in every state except DONE.

Reset
REQ-028 While reset_i=1: state=LEN_LO, index=0, byte_ready_o=0, imem_write_enable_o=0, imem_address_o=BASE_ADDR, imem_data_o=0, core_reset_o=1, done_o=0, error_o=0, checksum=0.
REQ-029 In the first cycle after reset_i falls, byte_ready_o SHALL be 1.
REQ-030 A reset asserted mid-load SHALL abort the load and restart at LEN_LO. Words already written SHALL NOT be erased.
REQ-031 reset_i SHALL take priority over an accepted byte in the same cycle.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: after the last WRITE, CHECK SHALL accept one byte. The loader SHALL go to DONE if that byte equals the XOR of all data bytes, and to ERROR otherwise.
REQ-033 LOADER_CHECKSUM_EN undefined: there SHALL be no CHECK state and no checksum logic. The last WRITE SHALL go directly to DONE.

Verification
REQ-034 Stream 02 00 13 05 10 00 93 05 20 00 (no checksum) -> writes 32'h00100513 @0x0 and 32'h00200593 @0x4, each as a single-cycle strobe; then done_o=1 and core_reset_o=0.
REQ-035 Count 00 00 -> DONE two cycles after the second byte, with no write strobe.
REQ-036 Count 01 01 with MAX_WORDS=256 -> error_o=1, core_reset_o stays 1, byte_ready_o=0.
REQ-037 Same stream as REQ-034 with byte_valid_i low for 5 cycles between every byte -> identical writes and addresses.
REQ-038 reset_i pulsed after 3 data bytes, then 01 00 EF BE AD DE -> a single write of 32'hDEADBEEF @BASE_ADDR.
REQ-039 LOADER_CHECKSUM_EN defined, 01 00 01 02 04 08 with checksum 0F -> done_o=1; same stream with checksum 0E -> error_o=1 after the word is written.
